sync_fifo: RTL and testbench

Single-clock synchronous FIFO that buffers WIDTH-bit words between a producer and a consumer in the same clock domain.
Provides full/empty status flags and one-cycle error pulses when a write to a full FIFO or a read from an empty FIFO is attempted.
Used as a general rate-decoupling buffer inside a single clock domain.

---
 rtl/sync_fifo_if.sv | 49 ++++
 rtl/sync_fifo.sv | 104 ++++++++++
 tb/tb_sync_fifo.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/sync_fifo_if.sv
// Handshake bundle between a producer/consumer pair and sync_fifo.
// count_o exists only when FIFO_COUNT_EN is defined.
interface sync_fifo_if #(
  parameter int WIDTH     = 8,
  parameter int PTR_WIDTH = 4
);

  logic             wr_en_i;
  logic [WIDTH-1:0] wdata_i;
  logic             full_o;
  logic             wr_error_o;
  logic             rd_en_i;
  logic [WIDTH-1:0] rdata_o;
  logic             empty_o;
  logic             rd_error_o;
`ifdef FIFO_COUNT_EN
  logic [PTR_WIDTH:0] count_o;
`endif

  // The producer/consumer side drives requests and observes status.
  modport master (
    output wr_en_i,
    output wdata_i,
    input  full_o,
    input  wr_error_o,
    output rd_en_i,
    input  rdata_o,
    input  empty_o,
`ifdef FIFO_COUNT_EN
    input  count_o,
`endif
    input  rd_error_o
  );

  modport slave (
    input  wr_en_i,
    input  wdata_i,
    output full_o,
    output wr_error_o,
    input  rd_en_i,
    output rdata_o,
    output empty_o,
`ifdef FIFO_COUNT_EN
    output count_o,
`endif
    output rd_error_o
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty flags and one-cycle reject pulses.
// Define FIFO_COUNT_EN to add the registered occupancy output count_o.
module sync_fifo #(
  parameter int DEPTH     = 16,
  parameter int WIDTH     = 8,
  parameter int PTR_WIDTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  sync_fifo_if.slave fifo
);

  localparam logic [PTR_WIDTH:0] PTR_ONE = {{PTR_WIDTH{1'b0}}, 1'b1};

  // Pointers carry one extra MSB that toggles on each wrap.
  logic [PTR_WIDTH:0] wrPtr_q, wrPtr_d;
  logic [PTR_WIDTH:0] rdPtr_q, rdPtr_d;
  logic [WIDTH-1:0]   rdata_q, rdata_d;
  logic               wrError_q, wrError_d;
  logic               rdError_q, rdError_d;

  logic [WIDTH-1:0]   mem [DEPTH];

  logic               fullNow;
  logic               emptyNow;
  logic               wrAccept;
  logic               rdAccept;

  always_comb begin
    emptyNow = (wrPtr_q == rdPtr_q);
    fullNow  = (wrPtr_q[PTR_WIDTH-1:0] == rdPtr_q[PTR_WIDTH-1:0]) &&
               (wrPtr_q[PTR_WIDTH] != rdPtr_q[PTR_WIDTH]);
    wrAccept = fifo.wr_en_i && !fullNow;
    rdAccept = fifo.rd_en_i && !emptyNow;
  end

  always_comb begin
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    rdata_d   = rdata_q;
    wrError_d = fifo.wr_en_i && fullNow;
    rdError_d = fifo.rd_en_i && emptyNow;
    if (wrAccept) begin
      wrPtr_d = wrPtr_q + PTR_ONE;
    end
    if (rdAccept) begin
      rdPtr_d = rdPtr_q + PTR_ONE;
      rdata_d = mem[rdPtr_q[PTR_WIDTH-1:0]];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      rdata_q   <= '0;
      wrError_q <= 1'b0;
      rdError_q <= 1'b0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      rdata_q   <= rdata_d;
      wrError_q <= wrError_d;
      rdError_q <= rdError_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wrAccept) begin
      mem[wrPtr_q[PTR_WIDTH-1:0]] <= fifo.wdata_i;
    end
  end

`ifdef FIFO_COUNT_EN
  logic [PTR_WIDTH:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (wrAccept && !rdAccept) begin
      count_d = count_q + PTR_ONE;
    end else if (rdAccept && !wrAccept) begin
      count_d = count_q - PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign fifo.count_o = count_q;
`endif

  assign fifo.full_o     = fullNow;
  assign fifo.empty_o    = emptyNow;
  assign fifo.rdata_o    = rdata_q;
  assign fifo.wr_error_o = wrError_q;
  assign fifo.rd_error_o = rdError_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Randomized self-checking bench for sync_fifo against a queue-based model.
module tb_sync_fifo;

  localparam int DEPTH     = 16;
  localparam int WIDTH     = 8;
  localparam int PTR_WIDTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] model [$];
  logic [WIDTH-1:0] expRdata = '0;
  logic [WIDTH-1:0] written [$];

  sync_fifo_if #(.WIDTH(WIDTH), .PTR_WIDTH(PTR_WIDTH)) fifoIf ();

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .PTR_WIDTH(PTR_WIDTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .fifo  (fifoIf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll(input logic expWrErr, input logic expRdErr);
    checkOutput("full",     32'(fifoIf.full_o),     32'(model.size() == DEPTH));
    checkOutput("empty",    32'(fifoIf.empty_o),    32'(model.size() == 0));
    checkOutput("rdata",    32'(fifoIf.rdata_o),    32'(expRdata));
    checkOutput("wr_error", 32'(fifoIf.wr_error_o), 32'(expWrErr));
    checkOutput("rd_error", 32'(fifoIf.rd_error_o), 32'(expRdErr));
`ifdef FIFO_COUNT_EN
    checkOutput("count",    32'(fifoIf.count_o),    32'(model.size()));
`endif
  endtask

  // One clock of stimulus; the model is updated from the pre-edge occupancy.
  task automatic applyStimulus(input logic wr, input logic [WIDTH-1:0] wd, input logic rd);
    bit wasFull;
    bit wasEmpty;
    fifoIf.wr_en_i = wr;
    fifoIf.wdata_i = wd;
    fifoIf.rd_en_i = rd;
    wasFull  = (model.size() == DEPTH);
    wasEmpty = (model.size() == 0);
    @(posedge clk);
    if (rd && !wasEmpty) expRdata = model.pop_front();
    if (wr && !wasFull)  model.push_back(wd);
    #1;
    checkAll(wr && wasFull, rd && wasEmpty);
  endtask

  task automatic applyReset();
    rst = 1'b1;
    fifoIf.wr_en_i = 1'b0;
    fifoIf.rd_en_i = 1'b0;
    fifoIf.wdata_i = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model.delete();
    expRdata = '0;
    checkAll(1'b0, 1'b0);
  endtask

  task automatic writeWords(input int n);
    logic [WIDTH-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = WIDTH'($urandom);
      written.push_back(w);
      applyStimulus(1'b1, w, 1'b0);
    end
  endtask

  task automatic readWords(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b1);
  endtask

  initial begin
    logic [WIDTH-1:0] lastWord;
    int wrPct;
    int rdPct;

    fifoIf.wr_en_i = 1'b0;
    fifoIf.rd_en_i = 1'b0;
    fifoIf.wdata_i = '0;
    @(negedge clk);

    // Fill, overflow by one, then drain with one extra read.
    applyReset();
    written.delete();
    writeWords(DEPTH);
    checkOutput("fill_full", 32'(fifoIf.full_o), 32'd1);
    writeWords(1);
    checkOutput("ovf_pulse", 32'(fifoIf.wr_error_o), 32'd1);
    applyStimulus(1'b0, '0, 1'b0);
    readWords(DEPTH);
    checkOutput("first16_last", 32'(fifoIf.rdata_o), 32'(written[DEPTH-1]));
    lastWord = fifoIf.rdata_o;
    readWords(1);
    checkOutput("udf_pulse", 32'(fifoIf.rd_error_o), 32'd1);
    checkOutput("udf_hold", 32'(fifoIf.rdata_o), 32'(lastWord));
    applyStimulus(1'b0, '0, 1'b0);

    // Preload 8 then stream through with simultaneous read and write.
    applyReset();
    writeWords(8);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, WIDTH'($urandom), 1'b1);
    checkOutput("stream_occ", 32'(model.size()), 32'd8);
    readWords(8);

    // Full FIFO with simultaneous read: write rejected, read performed.
    writeWords(DEPTH);
    applyStimulus(1'b1, WIDTH'($urandom), 1'b1);
    // Empty FIFO with simultaneous write: read rejected, write performed.
    readWords(DEPTH - 1);
    applyStimulus(1'b1, WIDTH'($urandom), 1'b1);
    readWords(2);

    // Reset in the middle of traffic, then a read on the fresh empty FIFO.
    writeWords(5);
    applyReset();
    applyStimulus(1'b0, '0, 1'b1);

    // Random traffic with phases biased toward filling or draining.
    for (int phase = 0; phase < 12; phase++) begin
      wrPct = (phase % 2 == 0) ? 80 : 25;
      rdPct = (phase % 2 == 0) ? 25 : 80;
      for (int i = 0; i < 40; i++) begin
        applyStimulus(($urandom_range(0, 99) < wrPct), WIDTH'($urandom),
                      ($urandom_range(0, 99) < rdPct));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
